// File: rtl/gshare_predictor.sv
`default_nettype none
// ============================================================================
// Module      : gshare_predictor
// Description : Zero-latency front-end branch predictor. It uses a table of
//               2-bit counters, a global history register and a return stack.
//               Define GSHARE_HASH_EN to hash the PC with the history (gshare);
//               leave it undefined for a PC-indexed (bimodal) table.
// Revision    : 1.0 - initial release
// ============================================================================
module gshare_predictor #(
    parameter int          IDX_W        = 6,
    parameter int          GHR_W        = 6,
    parameter int          RAS_W        = 3,
    parameter logic [31:0] EXCP_ADDRESS = 32'h0000_0100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             excp,
    input  logic             sret,
    input  logic             f_valid,
    input  logic [31:0]      f_pc,
    input  logic [31:0]      f_imm,
    input  logic [4:0]       f_rd,
    input  logic [4:0]       f_rs1,
    input  logic [1:0]       f_kind,
    input  logic             r_valid,
    input  logic             r_is_cond,
    input  logic             r_taken,
    input  logic             r_mispredict,
    input  logic [31:0]      r_pc,
    input  logic [31:0]      r_target,
    input  logic [GHR_W-1:0] r_ghr,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    output logic [GHR_W-1:0] pred_ghr,
    output logic [31:0]      mispredict_cnt
);

    localparam int         c_ctr_n    = 1 << IDX_W;
    localparam int         c_ras_n    = 1 << RAS_W;
    localparam logic [RAS_W:0] c_ras_full = {1'b1, {RAS_W{1'b0}}};

    logic [1:0]       r_ctr [0:c_ctr_n-1];
    logic [31:0]      r_ras [0:c_ras_n-1];
    logic [RAS_W-1:0] r_ras_ptr;
    logic [RAS_W:0]   r_ras_cnt;
    logic [GHR_W-1:0] r_hist;
    logic [31:0]      r_epc;
    logic [31:0]      r_mp_cnt;

    logic [IDX_W-1:0] w_f_idx;
    logic [IDX_W-1:0] w_r_idx;
    logic [31:0]      w_pc4;
    logic [31:0]      w_ras_top;
    logic             w_redirect;
    logic             w_accept;
    logic             w_is_ret;
    logic             w_taken;
    logic [31:0]      w_target;
    logic             w_push;
    logic             w_pop;
    logic             w_unused_r_pc;

`ifdef GSHARE_HASH_EN
    assign w_f_idx = f_pc[IDX_W+1:2] ^ IDX_W'(r_hist);
    assign w_r_idx = r_pc[IDX_W+1:2] ^ IDX_W'(r_ghr);
`else
    assign w_f_idx = f_pc[IDX_W+1:2];
    assign w_r_idx = r_pc[IDX_W+1:2];
`endif

    assign w_unused_r_pc = ^{r_pc[31:IDX_W+2], r_pc[1:0]};
    assign w_pc4         = f_pc + 32'd4;
    assign w_ras_top     = r_ras[r_ras_ptr - RAS_W'(1)];
    assign w_redirect    = excp | (r_valid & r_mispredict);
    assign w_accept      = f_valid & ~stall & ~w_redirect;
    assign w_is_ret      = (f_kind == 2'b11) && (f_rs1 == 5'd1) && (f_rd != 5'd1);

    // Redirect priority: reset, exception, resolved mispredict, then fetch kind.
    always_comb begin
        w_taken  = 1'b0;
        w_target = w_pc4;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        if (rst) begin
            w_target = 32'd0;
        end else if (excp) begin
            w_target = sret ? r_epc : EXCP_ADDRESS;
        end else if (r_valid && r_mispredict) begin
            w_target = r_target;
        end else if (f_valid) begin
            case (f_kind)
                2'b01: begin
                    w_taken = r_ctr[w_f_idx][1];
                    if (w_taken) w_target = f_pc + f_imm;
                end
                2'b10: begin
                    w_taken  = 1'b1;
                    w_target = f_pc + f_imm;
                    w_push   = (f_rd == 5'd1);
                end
                2'b11: begin
                    if (w_is_ret) begin
                        if (r_ras_cnt != '0) begin
                            w_taken  = 1'b1;
                            w_target = w_ras_top;
                            w_pop    = 1'b1;
                        end
                    end else begin
                        w_push = (f_rd == 5'd1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign pred_taken     = w_taken;
    assign pred_target    = w_target;
    assign pred_ghr       = r_hist;
    assign mispredict_cnt = r_mp_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_ctr_n; i++) r_ctr[i] <= 2'b01;
        end else if (r_valid && r_is_cond) begin
            if (r_taken && r_ctr[w_r_idx] != 2'b11)
                r_ctr[w_r_idx] <= r_ctr[w_r_idx] + 2'd1;
            else if (!r_taken && r_ctr[w_r_idx] != 2'b00)
                r_ctr[w_r_idx] <= r_ctr[w_r_idx] - 2'd1;
        end
    end

    // A resolved mispredict restores history and wins over any fetch shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= '0;
        end else if (r_valid && r_mispredict) begin
            r_hist <= r_is_cond ? GHR_W'({r_ghr, r_taken}) : r_ghr;
        end else if (w_accept && f_kind == 2'b01) begin
            r_hist <= GHR_W'({r_hist, w_taken});
        end
    end

    // Stack entries are left uninitialised; only pointer and count reset.
    always_ff @(posedge clk) begin
        if (w_accept && w_push) r_ras[r_ras_ptr] <= w_pc4;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ras_ptr <= '0;
            r_ras_cnt <= '0;
        end else if (w_accept && w_push) begin
            r_ras_ptr <= r_ras_ptr + RAS_W'(1);
            if (r_ras_cnt != c_ras_full) r_ras_cnt <= r_ras_cnt + (RAS_W+1)'(1);
        end else if (w_accept && w_pop) begin
            r_ras_ptr <= r_ras_ptr - RAS_W'(1);
            r_ras_cnt <= r_ras_cnt - (RAS_W+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_epc    <= '0;
            r_mp_cnt <= '0;
        end else begin
            if (excp && !sret && !stall) r_epc <= w_pc4;
            if (r_valid && r_mispredict && r_mp_cnt != 32'hFFFF_FFFF)
                r_mp_cnt <= r_mp_cnt + 32'd1;
        end
    end

endmodule
`default_nettype wire
